// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the SDF FFT output path.
//   LOG2N_DEF  default log2 of the transform size
//   BITREV_W   width handled by bitrev(); callers shift the result down
//              to reverse only their low LOG2N bits
//   bitrev()   full-width bit reversal
//   wr_state_t writer state (WRITE, DROP)
//   rd_state_t reader state (IDLE, READ)
package fft_pkg;

  localparam int LOG2N_DEF  = 5;
  localparam int DATA_W_DEF = 16;
  localparam int BITREV_W   = 16;

  typedef enum logic {
    WRITE = 1'b0,
    DROP  = 1'b1
  } wr_state_t;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

  function automatic logic [BITREV_W-1:0] bitrev(input logic [BITREV_W-1:0] k);
    logic [BITREV_W-1:0] r;
    for (int i = 0; i < BITREV_W; i++) begin
      r[i] = k[BITREV_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_out_if.sv
// fft_reorder_out_if: natural-order output stream of the FFT reorder buffer.
//   valid_o     sample valid (driven by master)
//   ready_i     downstream accepts (driven by slave)
//   data_out_r  signed real part
//   data_out_i  signed imaginary part
//   index_o     bin number of the presented sample
interface fft_reorder_out_if #(
  parameter int LOG2N  = 5,
  parameter int DATA_W = 16
);
  logic                     valid_o;
  logic                     ready_i;
  logic signed [DATA_W-1:0] data_out_r;
  logic signed [DATA_W-1:0] data_out_i;
  logic [LOG2N-1:0]         index_o;

  modport master (
    output valid_o, data_out_r, data_out_i, index_o,
    input  ready_i
  );

  modport slave (
    input  valid_o, data_out_r, data_out_i, index_o,
    output ready_i
  );
endinterface

// File: rtl/fft_reorder_bank.sv
// fft_reorder_bank: two N-deep sample banks for the ping-pong reorder.
//   clk        clock
//   we_i       write enable
//   wr_bank_i  bank selected for write
//   wr_addr_i  write address
//   wr_data_i  packed {real, imag} write data
//   rd_bank_i  bank selected for read
//   rd_addr_i  read address
//   rd_data_o  packed {real, imag}, combinational read
// Contents are not reset: stale data is never exposed because the full
// flags in the parent gate every read.
module fft_reorder_bank #(
  parameter int LOG2N = 5,
  parameter int W     = 32
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic             wr_bank_i,
  input  logic [LOG2N-1:0] wr_addr_i,
  input  logic [W-1:0]     wr_data_i,
  input  logic             rd_bank_i,
  input  logic [LOG2N-1:0] rd_addr_i,
  output logic [W-1:0]     rd_data_o
);

  localparam int N = 1 << LOG2N;

  logic [W-1:0] mem_q [2][N];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_bank_i][rd_addr_i];

endmodule

// File: rtl/fft_reorder_out.sv
// fft_reorder_out: output reorder buffer after the last SDF butterfly.
// Takes bit-reversed samples at up to one per cycle (no stall) and releases
// frames in natural bin order over a valid/ready stream via two banks.
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   valid_i    input sample present
//   data_in_r  signed input real part
//   data_in_i  signed input imaginary part
//   out_if     master side of the natural-order output stream
//   overflow_o sticky frame-drop flag
// Build option FFT_REORDER_OVF_EN: when defined, overflow_o is a sticky flag
// set at a dropped frame start; otherwise it is tied to 0. Dropping itself
// behaves the same either way.
//
// Writer states:
//   WRITE | current frame is being stored into wr_bank
//   DROP  | current frame arrived while wr_bank was still full; discarded
// Reader states:
//   IDLE  | waiting for full[rd_bank]
//   READ  | streaming rd_bank out, one bin per advance
module fft_reorder_out
  import fft_pkg::*;
#(
  parameter int LOG2N  = LOG2N_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  input  logic signed [DATA_W-1:0] data_in_r,
  input  logic signed [DATA_W-1:0] data_in_i,
  fft_reorder_out_if.master        out_if,
  output logic                     overflow_o
);

  localparam logic [LOG2N-1:0] LAST = '1;

  logic [LOG2N-1:0]         wr_cnt_q, wr_cnt_d;
  wr_state_t                wr_state_q, wr_state_d;
  logic                     wr_bank_q, wr_bank_d;
  logic [1:0]               full_q, full_d;
  rd_state_t                rd_state_q, rd_state_d;
  logic                     rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0]         rd_cnt_q, rd_cnt_d;
  logic                     valid_q, valid_d;
  logic signed [DATA_W-1:0] data_r_q, data_r_d;
  logic signed [DATA_W-1:0] data_i_q, data_i_d;
  logic [LOG2N-1:0]         index_q, index_d;

  logic                     frame_start;
  logic                     advance;
  logic                     release_rd;
  logic                     drop_start;
  logic                     we;
  logic [LOG2N-1:0]         wr_addr;
  logic [2*DATA_W-1:0]      rd_data;

  assign frame_start = valid_i && (wr_cnt_q == '0);
  assign advance     = (rd_state_q == READ) && (!valid_q || out_if.ready_i);
  assign release_rd  = advance && (rd_cnt_q == LAST);
  // A bank being emptied on this very edge is free for the new frame.
  assign drop_start  = frame_start && full_q[wr_bank_q] &&
                       !(release_rd && (rd_bank_q == wr_bank_q));
  assign we          = valid_i && (frame_start ? !drop_start : (wr_state_q == WRITE));
  // Reverse the full-width word, then keep the reversed low LOG2N bits.
  assign wr_addr     = LOG2N'(bitrev(BITREV_W'(wr_cnt_q)) >> (BITREV_W - LOG2N));

  fft_reorder_bank #(
    .LOG2N (LOG2N),
    .W     (2*DATA_W)
  ) u_bank (
    .clk       (clk),
    .we_i      (we),
    .wr_bank_i (wr_bank_q),
    .wr_addr_i (wr_addr),
    .wr_data_i ({data_in_r, data_in_i}),
    .rd_bank_i (rd_bank_q),
    .rd_addr_i (rd_cnt_q),
    .rd_data_o (rd_data)
  );

  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    wr_state_d = wr_state_q;
    wr_bank_d  = wr_bank_q;
    if (valid_i) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (frame_start) begin
        wr_state_d = drop_start ? DROP : WRITE;
      end
      if (we && (wr_cnt_q == LAST)) begin
        wr_bank_d = ~wr_bank_q;
      end
    end
  end

  always_comb begin
    full_d = full_q;
    if (release_rd) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (we && (wr_cnt_q == LAST)) begin
      full_d[wr_bank_q] = 1'b1;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_bank_d  = rd_bank_q;
    rd_cnt_d   = rd_cnt_q;
    valid_d    = valid_q;
    data_r_d   = data_r_q;
    data_i_d   = data_i_q;
    index_d    = index_q;
    case (rd_state_q)
      IDLE: begin
        if (out_if.ready_i) begin
          valid_d = 1'b0;
        end
        if (full_q[rd_bank_q]) begin
          rd_state_d = READ;
        end
      end
      default: begin
        if (advance) begin
          data_r_d = rd_data[2*DATA_W-1:DATA_W];
          data_i_d = rd_data[DATA_W-1:0];
          index_d  = rd_cnt_q;
          valid_d  = 1'b1;
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_cnt_q == LAST) begin
            rd_bank_d = ~rd_bank_q;
            // Back-to-back frames continue without an idle bubble.
            if (!full_q[~rd_bank_q]) begin
              rd_state_d = IDLE;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt_q   <= '0;
      wr_state_q <= WRITE;
      wr_bank_q  <= 1'b0;
      full_q     <= '0;
      rd_state_q <= IDLE;
      rd_bank_q  <= 1'b0;
      rd_cnt_q   <= '0;
      valid_q    <= 1'b0;
      data_r_q   <= '0;
      data_i_q   <= '0;
      index_q    <= '0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      wr_state_q <= wr_state_d;
      wr_bank_q  <= wr_bank_d;
      full_q     <= full_d;
      rd_state_q <= rd_state_d;
      rd_bank_q  <= rd_bank_d;
      rd_cnt_q   <= rd_cnt_d;
      valid_q    <= valid_d;
      data_r_q   <= data_r_d;
      data_i_q   <= data_i_d;
      index_q    <= index_d;
    end
  end

  assign out_if.valid_o    = valid_q;
  assign out_if.data_out_r = data_r_q;
  assign out_if.data_out_i = data_i_q;
  assign out_if.index_o    = index_q;

`ifdef FFT_REORDER_OVF_EN
  logic ovf_q, ovf_d;

  assign ovf_d = ovf_q || drop_start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow_o = ovf_q;
`else
  assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_fft_reorder_out.sv
// tb_fft_reorder_out: scoreboard bench for fft_reorder_out (LOG2N=5, DATA_W=16).
// A frame-level reference model tracks stored frames as a FIFO of
// natural-order bins and predicts when each bin is presented; a monitor
// compares the DUT output against the expected queue every cycle.
module tb_fft_reorder_out;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               valid_i = 1'b0;
  logic signed [15:0] din_r = '0;
  logic signed [15:0] din_i = '0;
  logic               ready_s = 1'b1;
  logic               overflow_o;

  fft_reorder_out_if #(.LOG2N(5), .DATA_W(16)) out_if ();
  assign out_if.ready_i = ready_s;

  fft_reorder_out #(.LOG2N(5), .DATA_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .data_in_r  (din_r),
    .data_in_i  (din_i),
    .out_if     (out_if),
    .overflow_o (overflow_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [36:0] sb [$];      // {index, r, i} registered but not yet consumed
  logic [31:0] fq [$];      // complete stored frames, 32 natural-order bins each
  logic [31:0] cur [32];    // frame being received, natural order
  int  wk = 0;
  int  m_rd = 0;
  bit  m_active = 0, m_valid = 0, m_drop = 0, m_ovf = 0;
  int  m_idx = 0;
  int  ready_mode = 0;
  int  hold_cnt = 0;
  bit  mon_en = 0;

  function automatic int brev5(input int k);
    int r = 0;
    for (int b = 0; b < 5; b++) if ((k & (1 << b)) != 0) r |= (1 << (4 - b));
    return r;
  endfunction

  function automatic bit decide_ready();
    case (ready_mode)
      0: return 1'b1;
      1: return ($urandom_range(0, 3) != 0);
      2: begin
        if (m_valid && m_idx == 7 && hold_cnt < 5) begin
          hold_cnt++;
          return 1'b0;
        end
        return 1'b1;
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step();
    int occ;
    bit adv, rel;
    occ = fq.size() / 32;
    adv = m_active && (!m_valid || ready_s);
    rel = adv && (m_rd == 31);
    if (m_active) begin
      if (adv) begin
        sb.push_back({m_rd[4:0], fq[m_rd]});
        m_valid = 1;
        m_idx = m_rd;
        if (m_rd == 31) begin
          repeat (32) void'(fq.pop_front());
          m_rd = 0;
          m_active = (occ > 1);
        end else begin
          m_rd++;
        end
      end
    end else begin
      if (ready_s) m_valid = 0;
      if (occ > 0) m_active = 1;
    end
    if (valid_i) begin
      if (wk == 0) begin
        m_drop = (occ == 2) && !rel;
        if (m_drop) m_ovf = 1;
      end
      if (!m_drop) cur[brev5(wk)] = {din_r, din_i};
      if (wk == 31 && !m_drop) for (int n = 0; n < 32; n++) fq.push_back(cur[n]);
      wk = (wk + 1) % 32;
    end
  endtask

  task automatic step(input bit v, input logic [15:0] r, input logic [15:0] i);
    valid_i = v;
    din_r = r;
    din_i = i;
    ready_s = decide_ready();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    mon_en = 0;
    valid_i = 0;
    ready_s = 1;
    rst = 1'b0;
    #1;
    check("rst_valid", 64'(out_if.valid_o), 64'd0);
    check("rst_data_r", 64'(out_if.data_out_r), 64'd0);
    check("rst_data_i", 64'(out_if.data_out_i), 64'd0);
    check("rst_index", 64'(out_if.index_o), 64'd0);
    check("rst_ovf", 64'(overflow_o), 64'd0);
    sb.delete();
    fq.delete();
    wk = 0; m_rd = 0; m_active = 0; m_valid = 0; m_drop = 0; m_ovf = 0; m_idx = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1;
  endtask

  // kind 0: r=k, i=-k; kind 1: random. gap 0: none, 1: alternate, 2: random
  task automatic send_frame(input int kind, input int gap);
    logic [15:0] r, i;
    for (int k = 0; k < 32; k++) begin
      if (kind == 0) begin
        r = 16'(k);
        i = 16'(-k);
      end else begin
        r = 16'($urandom);
        i = 16'($urandom);
      end
      step(1'b1, r, i);
      if (gap == 1) step(1'b0, 16'd0, 16'd0);
      else if (gap == 2) repeat ($urandom_range(0, 2)) step(1'b0, 16'd0, 16'd0);
    end
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while ((sb.size() != 0 || m_active || m_valid || fq.size() != 0) && c < budget) begin
      step(1'b0, 16'd0, 16'd0);
      c++;
    end
    vectors++;
    if (c >= budget) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d expected bins left after %0d cycles", sb.size(), c);
    end
  endtask

  always @(negedge clk) begin
    if (rst && mon_en) begin
      vectors++;
      if (out_if.valid_o !== m_valid) begin
        miscompares++;
        $display("FAIL valid_o: got %b expected %b at %0t", out_if.valid_o, m_valid, $time);
      end
      vectors++;
`ifdef FFT_REORDER_OVF_EN
      if (overflow_o !== m_ovf) begin
`else
      if (overflow_o !== 1'b0) begin
`endif
        miscompares++;
        $display("FAIL overflow_o: got %b at %0t", overflow_o, $time);
      end
      if (out_if.valid_o) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL bin: unexpected output idx %0d at %0t", out_if.index_o, $time);
        end else begin
          if ({out_if.index_o, out_if.data_out_r, out_if.data_out_i} !== sb[0]) begin
            miscompares++;
            $display("FAIL bin: got idx %0d r %h i %h expected idx %0d r %h i %h at %0t",
                     out_if.index_o, out_if.data_out_r, out_if.data_out_i,
                     sb[0][36:32], sb[0][31:16], sb[0][15:0], $time);
          end
          if (ready_s) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #2;
    do_reset();

    // single frame k / -k, full-rate
    ready_mode = 0;
    send_frame(0, 0);
    drain(200);

    // three frames back-to-back
    repeat (3) send_frame(1, 0);
    drain(300);

    // alternating valid
    send_frame(1, 1);
    drain(200);

    // backpressure while bin 7 is shown
    ready_mode = 2;
    hold_cnt = 0;
    send_frame(0, 0);
    drain(200);

    // ready low across three frames: third is dropped
    ready_mode = 3;
    repeat (3) send_frame(1, 0);
    step(1'b0, 16'd0, 16'd0);
`ifdef FFT_REORDER_OVF_EN
    check("ovf_after_drop", 64'(overflow_o), 64'd1);
`else
    check("ovf_after_drop", 64'(overflow_o), 64'd0);
`endif
    check("held_frames", 64'(fq.size() / 32), 64'd2);
    ready_mode = 0;
    drain(300);

    // reset after 10 samples of a frame, then a clean frame
    for (int k = 0; k < 10; k++) step(1'b1, 16'($urandom), 16'($urandom));
    do_reset();
    send_frame(0, 0);
    drain(200);

    // randomized traffic with random gaps and backpressure
    ready_mode = 1;
    repeat (6) send_frame(1, 2);
    drain(800);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fft_reorder_out.md
# fft_reorder_out

Output reorder buffer for the 32-point SDF FFT processor. It sits after the last butterfly stage and receives the transform results in bit-reversed bin order, one sample per valid cycle, with no input stall capability. Ping-pong storage releases the bins in natural order (0..N-1) over a valid/ready stream. It is the reader-side counterpart of the per-stage controllers, which pace the data into the pipeline.

## Interface
- LOG2N, 5: log2 of transform size; N = 2**LOG2N bins per frame.
- DATA_W, 16: signed width of each real/imag component.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- valid_i  in  1  one result sample present this cycle.
- data_in_r / data_in_i  in  DATA_W each  signed result sample.
- ready_i  in  1  downstream accepts the output this cycle.
- valid_o  out  1  output sample valid.
- data_out_r / data_out_i  out  DATA_W each  signed natural-order bin value.
- index_o  out  LOG2N  bin number of the current output.
- overflow_o  out  1  sticky frame-drop flag.

## Operation
- Storage: two banks (A/B) of N entries of {r,i}, each with a full flag. Reset state: wr_bank=A, rd_bank=A, both flags 0.
- Writer:
  - wr_cnt (LOG2N bits) advances on every valid_i and wraps N-1→0.
  - Sample k of a frame is written to address bitrev(k) of wr_bank.
  - Frame start (wr_cnt==0 with valid_i): if full[wr_bank] is set and not being released this same edge, the writer enters DROP for the whole frame. In DROP no writes occur, wr_cnt still counts, the bank does not switch, and overflow_o is set.
  - Otherwise the writer writes normally. On the edge that writes k=N-1, it sets full[wr_bank] and toggles wr_bank.
- Reader FSM:
  - IDLE→READ on the edge where full[rd_bank]==1.
  - In READ, an advance occurs on each edge with (!valid_o || ready_i). Each advance registers mem[rd_bank][rd_cnt] into data_out, sets index_o=rd_cnt and valid_o=1, and increments rd_cnt.
  - The advance that registers rd_cnt==N-1 clears full[rd_bank] and toggles rd_bank. If the new rd_bank is full, the FSM stays in READ with no gap; otherwise it goes to IDLE.
  - In IDLE, an edge with ready_i high clears valid_o.
- Handshake: while valid_o && !ready_i, data_out_r, data_out_i and index_o hold stable.
- Simultaneous release and frame start: a writer frame start in the same edge that releases that bank is accepted, not dropped.
- Arithmetic: pure data movement, no width change, no rounding.
- Reset mid-operation: all counters, flags, FSMs and outputs return to reset state immediately. A partially written frame is discarded.

## Timing
- Reset values: valid_o=0, data_out_r=0, data_out_i=0, index_o=0, overflow_o=0.
- Latency: with ready_i held high, the sample k=N-1 is captured at edge E. Then valid_o rises with bin 0 after edge E+2, and bin n appears after edge E+2+n.
- Throughput: a continuous input of 1 sample/cycle with ready_i=1 streams forever at 1 bin/cycle with no gaps and no drops.
- Writes use registered memory. Reads are combinational from the array into the registered output stage.

## Configuration
- FFT_REORDER_OVF_EN defined: overflow_o is a sticky flag, set at a dropped frame start and cleared only by reset.
- Not defined: overflow_o is constant 0 and the detection logic is absent. Drop behaviour is identical in both cases.

## Structure
- The shared package fft_pkg holds:
  - LOG2N default;
  - the bitrev function;
  - the writer state enum (WRITE, DROP);
  - the reader state enum (IDLE, READ).
- One sub-module, fft_reorder_bank: two N-deep banks with one write port (bank, addr, data) and one combinational read port (bank, addr).

## Test plan
- Single frame, data_in_r=k and data_in_i=-k for k=0..31, ready_i=1 → 32 consecutive valid_o with index_o=n, data_out_r=bitrev(n) (n=1→16, n=2→8, n=31→31) and data_out_i=-bitrev(n); first valid after edge E+2.
- Three frames back-to-back with ready_i=1 → 96 contiguous valid_o cycles, index_o sequence 0..31 repeated, overflow_o=0.
- Input valid_i alternating 1/0 for one frame → output begins 2 edges after the last capture, and 32 contiguous bins come out in correct order.
- ready_i low for 5 cycles while index_o=7 → data and index_o held at bin 7, bin 8 appears after ready_i rises, and no bin is lost or duplicated.
- ready_i held low while three full frames arrive → frames 1 and 2 are stored, frame 3 is dropped, and overflow_o=1 (0 without FFT_REORDER_OVF_EN). After ready_i=1, exactly frames 1 and 2 are output.
- rst pulsed low after 10 samples of a frame → all outputs 0 at once. A following complete frame is output correctly with no residue of the partial frame.
